vip_crop_window: RTL
====================

# vip_crop_window

Upstream framing stage for the histogram-equalization pipeline. It takes the raw sensor pixel stream (href/vsync/data), tracks pixel and line position, and forwards exactly an OUT_WIDTH × OUT_HEIGHT window at a runtime-selectable offset. Downstream stages that size their statistics on a fixed pixel total therefore see a constant pixel count per frame. It also flags input frames whose geometry does not match the configured sensor size.

## Interface

Parameters:
- BITS, 8: pixel data width.
- IN_WIDTH, 800: sensor active pixels per line.
- IN_HEIGHT, 600: sensor active lines per frame.
- OUT_WIDTH, 640: cropped pixels per line; must be ≤ IN_WIDTH.
- OUT_HEIGHT, 480: cropped lines per frame; must be ≤ IN_HEIGHT.

Ports:
- pclk, input, 1: pixel clock; the only clock.
- rst, input, 1: reset, synchronous, active-high.
- in_href, input, 1: input pixel valid.
- in_vsync, input, 1: input frame sync, active-high; its rising edge marks frame start.
- in_data, input, BITS: input pixel.
- cfg_x_off, input, 16: horizontal crop offset in pixels.
- cfg_y_off, input, 16: vertical crop offset in lines.
- out_href, output, 1: cropped pixel valid.
- out_vsync, output, 1: in_vsync delayed 1 cycle.
- out_data, output, BITS: cropped pixel; 0 when out_href=0.
- frame_err, output, 1: one-cycle pulse reporting a bad input frame geometry.

## Operation

- State machine:
  - WAIT_VS is entered on reset. In WAIT_VS, out_href is held at 0 and frame_err is held at 0.
  - A vsync rising edge (in_vsync=1 and the registered previous vsync=0) moves WAIT_VS to ACTIVE.
  - ACTIVE persists until the next reset.
- Frame start is the vsync rising edge. On it:
  - x_cnt and y_cnt are cleared.
  - Line-error flag is cleared.
  - Offsets are latched: x_off_l = min(cfg_x_off, IN_WIDTH−OUT_WIDTH), y_off_l = min(cfg_y_off, IN_HEIGHT−OUT_HEIGHT).
  - cfg changes at any other time have no effect until the next frame start.
- Pixel qualification:
  - A pixel is counted only when in_href=1 and in_vsync=0.
  - href asserted while vsync=1 is blanking: the pixel is neither counted nor forwarded.
- Counters:
  - x_cnt (16 bit) increments per counted pixel and saturates at 0xFFFF.
  - On an href falling edge, x_cnt clears and y_cnt (16 bit, saturating) increments.
  - If x_cnt ≠ IN_WIDTH at the href falling edge, the line-error flag is set; it stays set (sticky) until the next frame start.
- Window: a counted pixel is forwarded iff x_off_l ≤ x_cnt < x_off_l+OUT_WIDTH and y_off_l ≤ y_cnt < y_off_l+OUT_HEIGHT. Comparisons use the current pre-increment x_cnt and y_cnt.
- frame_err is evaluated at every frame start while in ACTIVE (not on the WAIT_VS→ACTIVE edge). It pulses when any of the following holds for the frame just ended:
  - y_cnt ≠ IN_HEIGHT;
  - the line-error flag is set;
  - in_href was high on the previous cycle (open line; the open line is not counted into y_cnt).
- Malformed frames are still forwarded using window logic only, so out_href totals may differ from OUT_WIDTH×OUT_HEIGHT; frame_err is the indication.
- Offset arithmetic uses 17-bit sums so there is no overflow.

## Timing

- All outputs are registered; latency is 1 cycle from input to out_href/out_vsync/out_data.
- out_vsync = in_vsync delayed 1 cycle, in every state including WAIT_VS.
- frame_err is asserted in the cycle after the vsync rising edge, i.e. coincident with out_vsync rising, for exactly 1 cycle.
- Reset values: out_href=0, out_vsync=0, out_data=0, frame_err=0, state=WAIT_VS, counters=0, x_off_l=y_off_l=0, line-error flag=0.
- Reset mid-frame: outputs are 0 from the cycle after rst is sampled. The remainder of the frame is dropped and output resumes only after the next vsync rising edge.
- Back-to-back frames with no vsync low gap: there is no rising edge, so the frames are treated as one frame.
- When a vsync rising edge and an href falling edge occur in the same cycle, frame start has priority.

## Test plan

- Nominal: 800×600 frame, cfg=(80,60):
  - exactly 307200 out_href cycles;
  - first output pixel = input pixel (x=80, y=60);
  - last output pixel = input pixel (719, 539);
  - frame_err=0.
- Clamp: cfg_x_off=500, cfg_y_off=200 → effective offset (160,120); first output pixel = input (160,120).
- Offset change mid-frame: cfg changes from (0,0) to (100,100) at line 300 → current frame still uses (0,0); next frame starts at (100,100).
- Geometry errors:
  - line 10 has 799 pixels → frame_err pulses once, 1 cycle after the next vsync rising edge;
  - a frame of 599 lines → same pulse;
  - a correct following frame → no pulse.
- Reset mid-frame at line 200: out_href stays 0 through the rest of that frame; the next full frame produces 307200 pixels; no frame_err on the first vsync edge after reset.
- Blanking: href pulses while vsync=1 → no out_href and no effect on counters; out_vsync tracks in_vsync with 1-cycle delay.

Source files
------------

// File: rtl/vip_crop_window.sv
// Crops a fixed OUT_WIDTH x OUT_HEIGHT window out of a raw href/vsync pixel stream
// at a per-frame offset, and flags input frames whose geometry differs from the sensor size.
module vip_crop_window #(
    parameter int BITS       = 8,
    parameter int IN_WIDTH   = 800,
    parameter int IN_HEIGHT  = 600,
    parameter int OUT_WIDTH  = 640,
    parameter int OUT_HEIGHT = 480
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            in_href,
    input  logic            in_vsync,
    input  logic [BITS-1:0] in_data,
    input  logic [15:0]     cfg_x_off,
    input  logic [15:0]     cfg_y_off,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_data,
    output logic            frame_err
);

    localparam logic [15:0] IN_W16    = 16'(IN_WIDTH);
    localparam logic [15:0] IN_H16    = 16'(IN_HEIGHT);
    localparam logic [15:0] X_OFF_MAX = 16'(IN_WIDTH - OUT_WIDTH);
    localparam logic [15:0] Y_OFF_MAX = 16'(IN_HEIGHT - OUT_HEIGHT);
    localparam logic [16:0] OUT_W17   = 17'(OUT_WIDTH);
    localparam logic [16:0] OUT_H17   = 17'(OUT_HEIGHT);

    typedef enum logic {
        WAIT_VS,
        ACTIVE
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [15:0] clamp_off(input logic [15:0] v, input logic [15:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    // 17-bit upper bound so lo + span can never wrap
    function automatic logic in_range(input logic [15:0] pos, input logic [15:0] lo,
                                      input logic [16:0] span);
        return ({1'b0, pos} >= {1'b0, lo}) && ({1'b0, pos} < ({1'b0, lo} + span));
    endfunction

    state_t          state;
    logic            vsync_d;
    logic            href_d;
    logic            pix_d;
    logic [15:0]     x_cnt;
    logic [15:0]     y_cnt;
    logic [15:0]     x_off_l;
    logic [15:0]     y_off_l;
    logic            line_err;

    logic            vs_rise_p0;
    logic            pix_p0;
    logic            line_end_p0;
    logic            win_p0;
    logic            vld_p0;
    logic            err_p0;

    logic            vld_p1;
    logic            vsync_p1;
    logic            err_p1;
    logic [BITS-1:0] data_p1;

    // ---- stage p0: qualify the incoming pixel against position and window ----
    assign vs_rise_p0  = in_vsync & ~vsync_d;
    assign pix_p0      = in_href & ~in_vsync;
    // Only qualified pixels open a line, so href pulses inside vsync never end one.
    assign line_end_p0 = pix_d & ~in_href;
    assign win_p0      = in_range(x_cnt, x_off_l, OUT_W17) && in_range(y_cnt, y_off_l, OUT_H17);
    assign vld_p0      = (state == ACTIVE) && pix_p0 && win_p0;
    assign err_p0      = (state == ACTIVE) && vs_rise_p0 &&
                         ((y_cnt != IN_H16) || line_err || href_d);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state    <= WAIT_VS;
            vsync_d  <= 1'b0;
            href_d   <= 1'b0;
            pix_d    <= 1'b0;
            x_cnt    <= '0;
            y_cnt    <= '0;
            x_off_l  <= '0;
            y_off_l  <= '0;
            line_err <= 1'b0;
            vld_p1   <= 1'b0;
            vsync_p1 <= 1'b0;
            err_p1   <= 1'b0;
        end else begin
            vsync_d  <= in_vsync;
            href_d   <= in_href;
            pix_d    <= pix_p0;
            vld_p1   <= vld_p0;
            vsync_p1 <= in_vsync;
            err_p1   <= err_p0;
            if (vs_rise_p0) begin
                state    <= ACTIVE;
                x_cnt    <= '0;
                y_cnt    <= '0;
                line_err <= 1'b0;
                x_off_l  <= clamp_off(cfg_x_off, X_OFF_MAX);
                y_off_l  <= clamp_off(cfg_y_off, Y_OFF_MAX);
            end else if (state == ACTIVE) begin
                if (line_end_p0) begin
                    x_cnt <= '0;
                    y_cnt <= sat_inc(y_cnt);
                    if (x_cnt != IN_W16) begin
                        line_err <= 1'b1;
                    end
                end else if (pix_p0) begin
                    x_cnt <= sat_inc(x_cnt);
                end
            end
        end
    end

    // ---- stage p1: registered output pixel ----
    always_ff @(posedge pclk) begin
        if (rst) begin
            data_p1 <= '0;
        end else begin
            data_p1 <= vld_p0 ? in_data : '0;
        end
    end

    assign out_href  = vld_p1;
    assign out_vsync = vsync_p1;
    assign out_data  = data_p1;
    assign frame_err = err_p1;

endmodule
